// File: rtl/kronos_ifetch.sv
// Kronos RV32I instruction fetch: single-outstanding word reads, one output
// register plus one skid entry, branch redirect with flush of in-flight data.

package kronos_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;
endpackage

// state    | meaning
// ST_REQ   | requesting instr_addr; instr_req low only in the first cycle after reset
// ST_HOLD  | output and skid both full, bus idle until decode frees a slot
// ST_DRAIN | flushed request still on the bus; its data is dropped, then fetch restarts at redirect_pc
module kronos_ifetch
    import kronos_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic [31:0] branch_target,
    input  logic        branch,
    output pipeIFID_t   fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

    state_t      state;
    logic [31:0] skid_pc;
    logic [31:0] skid_ir;
    logic        skid_vld;
    logic [31:0] redirect_pc;

    logic        xfer;
    logic        slot_free;
    logic [31:0] target_pc;
    logic [31:0] pc_next;
    logic        unused_target_lsb;

    assign xfer              = instr_req & instr_ack;
    assign slot_free         = ~fetch_vld | fetch_rdy;
    assign target_pc         = {branch_target[31:2], 2'b00};
    assign pc_next           = instr_addr + 32'd4;
    assign unused_target_lsb = ^branch_target[1:0];

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state       <= ST_REQ;
            instr_req   <= 1'b0;
            instr_addr  <= BOOT_PC;
            fetch       <= '0;
            fetch_vld   <= 1'b0;
            skid_pc     <= '0;
            skid_ir     <= '0;
            skid_vld    <= 1'b0;
            redirect_pc <= BOOT_PC;
        end else if (branch) begin
            fetch_vld   <= 1'b0;
            skid_vld    <= 1'b0;
            redirect_pc <= target_pc;
            // A request still waiting for its ack cannot be withdrawn; let it finish in DRAIN.
            if (xfer || !instr_req) begin
                instr_addr <= target_pc;
                instr_req  <= 1'b1;
                state      <= ST_REQ;
            end else begin
                state <= ST_DRAIN;
            end
        end else begin
            unique case (state)
                ST_REQ: begin
                    instr_req <= 1'b1;
                    if (xfer) begin
                        instr_addr <= pc_next;
                        if (slot_free && !skid_vld) begin
                            fetch     <= {instr_addr, instr_data};
                            fetch_vld <= 1'b1;
                        end else begin
                            skid_pc   <= instr_addr;
                            skid_ir   <= instr_data;
                            skid_vld  <= 1'b1;
                            instr_req <= 1'b0;
                            state     <= ST_HOLD;
                        end
                    end else if (fetch_vld && fetch_rdy) begin
                        fetch_vld <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (slot_free) begin
                        fetch     <= {skid_pc, skid_ir};
                        fetch_vld <= 1'b1;
                        skid_vld  <= 1'b0;
                        instr_req <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (fetch_vld && fetch_rdy) begin
                        fetch_vld <= 1'b0;
                    end
                    if (xfer) begin
                        instr_addr <= redirect_pc;
                        state      <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_ifetch.sv
// Randomized scoreboard bench for kronos_ifetch: two instances (boot 0x100 and
// boot 0xFFFFFFF8) share stimulus; each has its own reference model and monitor.
module tb_kronos_ifetch;
    import kronos_pkg::*;

    logic        clk = 1'b0;
    logic        rstz;
    logic        instr_ack;
    logic        branch;
    logic        fetch_rdy;
    logic [31:0] branch_target;
    logic [31:0] junk;
    bit          boot_dir;
    bit          end_req;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h", g, name, act, exp);
        end
    endtask

    task automatic chk1(input int g, input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0b expected %0b", g, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam logic [31:0] BOOT = (g == 0) ? 32'h0000_0100 : 32'hFFFF_FFF8;

        logic [31:0] instr_addr;
        logic [31:0] instr_data;
        logic        instr_req;
        logic        fetch_vld;
        pipeIFID_t   fetch;

        assign instr_data = instr_ack ? mem_word(instr_addr) : junk;

        kronos_ifetch #(.BOOT_ADDR(BOOT)) u_dut (
            .clk          (clk),
            .rstz         (rstz),
            .instr_addr   (instr_addr),
            .instr_req    (instr_req),
            .instr_data   (instr_data),
            .instr_ack    (instr_ack),
            .branch_target(branch_target),
            .branch       (branch),
            .fetch        (fetch),
            .fetch_vld    (fetch_vld),
            .fetch_rdy    (fetch_rdy)
        );

        logic [31:0] exp_q[$];
        logic [31:0] bus_exp;
        int          occ;
        bit          pending;
        int          cyc;
        int          hs_cnt = 0;
        bit          done = 0;
        bit          p_valid, p_req, p_ack, p_branch, p_vld, p_rdy, p_lat;
        logic [31:0] p_addr, p_target, p_lat_pc;
        pipeIFID_t   p_fetch;

        // Reference model: expected bus address stream and expected output order.
        always @(negedge clk) begin
            bit xfer, counted, hs;
            if (!rstz) begin
                chk1(g, "rst_req", instr_req, 1'b0);
                chk1(g, "rst_vld", fetch_vld, 1'b0);
                chk(g, "rst_addr", instr_addr, BOOT);
                exp_q.delete();
                bus_exp = BOOT;
                occ     = 0;
                pending = 0;
                p_valid = 0;
                cyc     = 0;
            end else begin
                xfer = instr_req && instr_ack;
                hs   = fetch_vld && fetch_rdy;
                if (p_valid) begin
                    if (p_req && !p_ack) begin
                        chk1(g, "req_held", instr_req, 1'b1);
                        chk(g, "addr_held", instr_addr, p_addr);
                    end
                    if (p_branch) begin
                        chk1(g, "branch_flush", fetch_vld, 1'b0);
                        if (!(p_req && !p_ack)) begin
                            chk1(g, "branch_req", instr_req, 1'b1);
                            chk(g, "branch_addr", instr_addr, {p_target[31:2], 2'b00});
                        end
                    end else if (p_vld && !p_rdy) begin
                        chk1(g, "stall_vld", fetch_vld, 1'b1);
                        chk(g, "stall_pc", fetch.pc, p_fetch.pc);
                        chk(g, "stall_ir", fetch.ir, p_fetch.ir);
                    end
                    if (p_lat) begin
                        chk1(g, "latency_vld", fetch_vld, 1'b1);
                        chk(g, "latency_pc", fetch.pc, p_lat_pc);
                    end
                end
                if (boot_dir) begin
                    if (cyc >= 2 && cyc <= 4) begin
                        chk1(g, "boot_vld", fetch_vld, 1'b1);
                        chk(g, "boot_pc", fetch.pc, BOOT + 32'(4 * (cyc - 2)));
                    end
                    cyc++;
                end
                if (occ == 2) chk1(g, "skid_full_req", instr_req, 1'b0);
                chk1(g, "occupancy", occ <= 2, 1'b1);
                if (instr_req) chk(g, "align", {30'b0, instr_addr[1:0]}, 32'h0);

                counted  = xfer && !branch && !pending;
                p_lat    = counted && (!fetch_vld || fetch_rdy);
                p_lat_pc = bus_exp;
                if (counted) begin
                    chk(g, "bus_addr", instr_addr, bus_exp);
                    exp_q.push_back(bus_exp);
                    bus_exp = bus_exp + 32'd4;
                end
                if (branch) begin
                    exp_q.delete();
                    occ     = 0;
                    bus_exp = {branch_target[31:2], 2'b00};
                    pending = instr_req && !instr_ack;
                end else begin
                    occ = occ + (counted ? 1 : 0) - (hs ? 1 : 0);
                    if (xfer) pending = 0;
                end
                p_valid  = 1;
                p_req    = instr_req;
                p_ack    = instr_ack;
                p_branch = branch;
                p_vld    = fetch_vld;
                p_rdy    = fetch_rdy;
                p_addr   = instr_addr;
                p_target = branch_target;
                p_fetch  = fetch;
            end
        end

        // Monitor: every accepted output must be the oldest expected instruction.
        always @(negedge clk) begin
            logic [31:0] exp_pc;
            if (rstz && fetch_vld && fetch_rdy && !branch) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected_out: got pc %h expected no output", g, fetch.pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk(g, "out_pc", fetch.pc, exp_pc);
                    chk(g, "out_ir", fetch.ir, mem_word(exp_pc));
                end
            end
            if (end_req && !done) begin
                done = 1;
                chk1(g, "progress", hs_cnt > 200, 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        junk = $urandom;
    endtask

    initial begin
        int ack_pct;
        rstz          = 1'b0;
        instr_ack     = 1'b1;
        fetch_rdy     = 1'b1;
        branch        = 1'b0;
        branch_target = 32'h0;
        junk          = 32'h0;
        boot_dir      = 1'b1;
        end_req       = 1'b0;
        repeat (3) step();
        rstz = 1'b1;
        repeat (8) step();
        boot_dir = 1'b0;

        fetch_rdy = 1'b0;
        repeat (5) step();
        fetch_rdy = 1'b1;
        repeat (4) step();

        instr_ack = 1'b0;
        repeat (3) step();
        instr_ack = 1'b1;
        repeat (4) step();

        instr_ack = 1'b0;
        step();
        branch        = 1'b1;
        branch_target = 32'h0000_2002;
        step();
        branch = 1'b0;
        step();
        instr_ack = 1'b1;
        repeat (6) step();

        fetch_rdy = 1'b0;
        repeat (4) step();
        branch        = 1'b1;
        branch_target = $urandom;
        step();
        branch    = 1'b0;
        fetch_rdy = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 3000; i++) begin
            ack_pct       = ((i / 400) % 2 == 0) ? 45 : 90;
            instr_ack     = ($urandom_range(99) < ack_pct);
            fetch_rdy     = ($urandom_range(9) < 7);
            branch        = ($urandom_range(39) == 0);
            branch_target = $urandom;
            if (i == 1000 || i == 2000) begin
                branch    = 1'b0;
                fetch_rdy = 1'b0;
                repeat (3) step();
                rstz = 1'b0;
                repeat (2) step();
                rstz = 1'b1;
            end
            step();
        end

        branch  = 1'b0;
        end_req = 1'b1;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kronos_ifetch.md
# kronos_ifetch

Kronos RV32I instruction fetch stage. It issues word reads on the instruction bus, holds one fetched instruction plus one skid entry, and presents {pc, ir} on the IF/ID valid/ready interface to the decode stage. A branch redirect from downstream flushes in-flight and buffered instructions and restarts fetch at the target.

## Interface
- BOOT_ADDR, 32'h0, first fetch address after reset; bits [1:0] must be 0.
- clk  input  1  clock
- rstz  input  1  reset, asynchronous, active-low
- instr_addr  output  32  instruction bus word address, always 4-byte aligned
- instr_req  output  1  read request; held with stable instr_addr until instr_ack
- instr_data  input  32  read data, valid in the instr_req && instr_ack cycle
- instr_ack  input  1  completes the transfer in the cycle it is high while instr_req is high
- branch_target  input  32  redirect address; bits [1:0] ignored (forced 0)
- branch  input  1  redirect/flush strobe, one cycle
- fetch  output  pipeIFID_t  {pc, ir} to decode
- fetch_vld  output  1  fetch holds a valid instruction
- fetch_rdy  input  1  decode accepts fetch this cycle

## Operation
- Single outstanding request. Transfer = instr_req && instr_ack in the same cycle; ack is combinational-allowed (same cycle as req) or any later cycle.
- Storage: output register (fetch, fetch_vld) plus one skid entry (skid_pc, skid_ir, skid_vld).
- slot_free = ~fetch_vld | fetch_rdy.
- State machine:
  - REQ: instr_req=1. On transfer with slot_free and ~skid_vld: load fetch <= {instr_addr, instr_data}, fetch_vld <= 1, instr_addr <= instr_addr+4, stay REQ. On transfer with ~slot_free: load skid entry, instr_addr <= +4, go HOLD.
  - HOLD: instr_req=0. When slot_free: move skid to fetch, skid_vld <= 0, go REQ.
  - DRAIN: instr_req=1 at old address (bus rule: request cannot be withdrawn); on transfer discard data, instr_addr <= redirect_pc, go REQ.
- Output consume without new data: fetch_rdy && fetch_vld && no load this cycle -> fetch_vld <= 0.
- Branch (highest priority, any state):
  - fetch_vld <= 0, skid_vld <= 0, redirect_pc <= {branch_target[31:2],2'b00}.
  - In REQ with no transfer this cycle -> DRAIN (pending request completes, data dropped).
  - In REQ with transfer this cycle, or in HOLD/DRAIN-with-transfer -> instr_addr <= redirect target, go REQ; returned data discarded.
  - In DRAIN without transfer -> stay DRAIN, redirect_pc updated to newest target.
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no fault.
- fetch.pc always equals the address the fetch.ir was read from.

## Timing
- Reset values: instr_req=0, instr_addr=BOOT_ADDR, fetch_vld=0, skid_vld=0, state REQ-pending (instr_req rises first cycle after rstz deasserts). fetch contents undefined until fetch_vld.
- Reset mid-transfer: all state cleared asynchronously; outstanding bus ack after reset is ignored (instr_req=0).
- Latency: transfer in cycle N -> fetch_vld=1 with that instruction in cycle N+1.
- Throughput: with instr_ack tied high and fetch_rdy high, one instruction per cycle, consecutive PCs.
- Backpressure: at most one extra instruction fetched after fetch_rdy drops; instr_req low in HOLD.
- Branch in cycle N: fetch_vld=0 in N+1; if no request pending, instr_addr=target with instr_req=1 in N+1; first target instruction visible earliest N+2.
- fetch and fetch_vld are stable while fetch_vld && ~fetch_rdy (no branch).

## Test plan
- Reset with BOOT_ADDR=32'h100, ack tied 1, fetch_rdy=1 -> fetch.pc 0x100,0x104,0x108 on consecutive cycles starting 2 cycles after reset release, ir matches memory.
- fetch_rdy low for 5 cycles at pc 0x108 -> fetch held at 0x108, exactly one further transfer (0x10C) into skid, instr_req low; on release 0x108,0x10C,0x110 in order, no loss/duplication.
- Ack delayed 3 cycles -> instr_addr/instr_req stable throughout; fetch_vld rises cycle after ack.
- Branch to 32'h2002 while request to 0x110 pending (ack 2 cycles later) -> 0x110 data discarded, next request addr 0x2000, fetch.pc 0x2000 next valid; fetch_vld 0 in between.
- Branch coincident with ack and with skid full -> both instructions dropped, next fetch.pc = target.
- BOOT_ADDR=32'hFFFF_FFF8 -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rstz asserted mid-stall -> fetch_vld=0, instr_req=0 immediately, restart at BOOT_ADDR.
